mul_16bit_seq: RTL and testbench
================================

# mul_16bit_seq

Sequential shift-add multiply-accumulate unit that computes `product = Q * B + R`. It is the inverse of the 16-bit by 8-bit divider: feeding it a quotient, divisor and remainder rebuilds the original dividend. The block sits beside the divider, either as a self-check path or as the multiply half of the same arithmetic datapath. It handles one operation at a time, using a start/busy/done handshake and a fixed 8-cycle computation.

## Interface
Parameters: none. Widths are fixed at 16-bit Q, 8-bit B, 16-bit R and 24-bit product.

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `start`  input  1  request a new operation; sampled on the rising edge of `clk`
- `Q`  input  16  multiplicand, unsigned (the divider's quotient)
- `B`  input  8  multiplier, unsigned (the divisor)
- `R`  input  16  addend, unsigned (the divider's remainder)
- `busy`  output  1  high while an operation is in progress
- `done`  output  1  one-cycle pulse when `product` has just been updated
- `product`  output  24  registered result, unsigned

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: 8 shift-add iterations.
  - DONE: single cycle, result presented.
- Transitions:
  - IDLE -> CALC when `start` = 1.
  - CALC -> DONE after the 8th iteration.
  - DONE -> CALC when `start` = 1.
  - DONE -> IDLE when `start` = 0.
- Accepting a request (from IDLE or DONE):
  - latch `Q` zero-extended to 24 bits into the multiplicand register `mcand`;
  - latch `B` into the multiplier register `mplier`;
  - latch `R` zero-extended to 24 bits into the accumulator `acc`;
  - clear the 3-bit iteration counter.
- Each CALC cycle:
  - if `mplier[0]` = 1, set `acc` = `acc` + `mcand`;
  - shift `mcand` left by 1 and `mplier` right by 1;
  - increment the counter.
  - When the counter reaches 7, that is the last iteration. Load `product` with the updated `acc` and go to DONE.
- Arithmetic width:
  - The maximum result is 65535*255 + 65535 = 16776960 (0xFFFF00), which is below 2^24.
  - No overflow is possible and no carry out is needed.
  - `mcand` never shifts out a set bit within 8 iterations.
- There is no early termination. B = 0 or B = 1 still takes 8 cycles.
- `start` is ignored in CALC. Inputs are not re-sampled while busy.
- `Q`, `B` and `R` only need to be stable in the cycle `start` is sampled.
- `product` holds its last value until the next completion. It does not change during CALC.
- `busy` = 1 exactly in CALC. `done` = 1 exactly in DONE. Both are decoded from registered state, with no combinational path from any input.

## Timing
- Reset (`rst_n` = 0, asynchronous):
  - state goes to IDLE;
  - `busy` = 0, `done` = 0, `product` = 0;
  - internal registers are cleared.
- Reset asserted mid-operation aborts the operation. No `done` is produced and `product` reads 0.
- Release of `rst_n` is synchronous to `clk` at the system level. The block accepts `start` on the first rising edge after release.
- Latency: with `start` sampled at edge N:
  - `busy` is high during cycles N+1 to N+8;
  - `done` is high and `product` is valid from edge N+8 for one cycle.
- Start-to-result latency is 8 cycles.
- Throughput:
  - back-to-back with `start` held high in DONE: one result every 9 cycles;
  - from IDLE: 9 cycles plus the idle gap.
- `start` asserted in the same cycle as `done` is accepted. `done` still pulses for exactly one cycle, and `busy` rises on the next edge.

## Test plan
- Reset: hold `rst_n` = 0 with `start` = 1.
  - Required: `busy` = 0, `done` = 0, `product` = 0.
  - After release, one `start` gives `done` exactly 8 edges later.
- Basic: Q = 100, B = 7, R = 3.
  - Required: `busy` high for 8 cycles, then `done` pulses with `product` = 703, and `product` stays 703 afterwards.
- Divider round-trip: Q = 3846, B = 13, R = 2 (the divider's output for A = 50000, B = 13).
  - Required: `product` = 50000.
- Extremes:
  - Q = 65535, B = 255, R = 65535 -> `product` = 16776960 (0xFFFF00).
  - Q = 1234, B = 0, R = 56 -> `product` = 56, still 8 cycles.
- Handshake:
  - pulse `start` with Q = 5, B = 5, R = 0;
  - at cycle 3 of CALC, assert `start` with Q = 9, B = 9, R = 9;
  - Required: that request is ignored, and the result is 25.
  - Then hold `start` high in DONE with Q = 2, B = 3, R = 1.
  - Required: `product` = 7 exactly 9 cycles after the previous `done`.
- Reset mid-operation: drop `rst_n` at cycle 4 of CALC.
  - Required: `busy` = 0 immediately, `product` = 0, and no `done` pulse.
  - A fresh operation after release completes correctly.

Source files
------------

// File: rtl/mul_16bit_seq.sv
// Sequential shift-add multiply-accumulate: product = Q * B + R.
// Rebuilds a 16/8 divider's dividend from its quotient, divisor and
// remainder. One operation at a time, fixed 8 iterations, start/busy/done
// handshake. All outputs come straight from registers.
module mul_16bit_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] Q,
  input  logic [7:0]  B,
  input  logic [15:0] R,
  output logic        busy,
  output logic        done,
  output logic [23:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [23:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [23:0] r_acc;
  logic [2:0]  r_cnt;
  logic [23:0] r_product;
  logic        r_busy;
  logic        r_done;

  // Conditional add for the current iteration; 24 bits cannot overflow
  // because the largest possible result is 0xFFFF00.
  logic [23:0] w_acc_next;
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Control FSM plus datapath registers; busy/done are registered alongside
  // the state so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mcand  <= {8'd0, Q};
            r_mplier <= B;
            r_acc    <= {8'd0, R};
            r_cnt    <= '0;
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end else begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
          end
        end
        S_CALC: begin
          // start is deliberately ignored here; operands are only taken
          // when a request is accepted.
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[22:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[7:1]};
          r_cnt    <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_product <= w_acc_next;
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_mul_16bit_seq.sv
// Directed and randomized checks of mul_16bit_seq against an arithmetic
// reference (Q * B + R) with cycle-exact handshake timing.
module tb_mul_16bit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] Q = '0;
  logic [7:0]  B = '0;
  logic [15:0] R = '0;
  logic        busy;
  logic        done;
  logic [23:0] product;

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] last_prod = '0;

  mul_16bit_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .Q       (Q),
    .B       (B),
    .R       (R),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] model(input logic [15:0] q, input logic [7:0] b,
                                        input logic [15:0] r);
    int unsigned p;
    p = int'(q) * int'(b) + int'(r);
    return p[23:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full operation from an idle/done state with exact latency checks.
  task automatic run_op(input string tag, input logic [15:0] q, input logic [7:0] b,
                        input logic [15:0] r);
    logic [23:0] exp;
    logic        busy_ok;
    logic        hold_ok;
    exp = model(q, b, r);
    start = 1'b1; Q = q; B = b; R = r;
    tick();
    start = 1'b0;
    Q = 16'($urandom); B = 8'($urandom); R = 16'($urandom);
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      if (product !== last_prod) hold_ok = 1'b0;
      if (i < 7) tick();
    end
    chk({tag, "_busy8"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_hold_calc"}, {31'd0, hold_ok}, 32'd1);
    tick();
    chk({tag, "_done"}, {30'd0, busy, done}, 32'd1);
    chk({tag, "_product"}, {8'd0, product}, {8'd0, exp});
    last_prod = exp;
    tick();
    chk({tag, "_done_1cyc"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_product_hold"}, {8'd0, product}, {8'd0, exp});
  endtask

  initial begin
    int ed;
    logic no_done;

    // Reset held with start asserted
    rst_n = 1'b0; start = 1'b1; Q = 16'd11; B = 8'd3; R = 16'd4;
    tick(); tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {8'd0, product}, 32'd0);
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    ed = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      ed = i;
      if (done === 1'b1) break;
    end
    chk("rst_release_latency", ed, 32'd8);
    chk("rst_release_product", {8'd0, product}, {8'd0, model(16'd11, 8'd3, 16'd4)});
    last_prod = model(16'd11, 8'd3, 16'd4);
    tick();

    // Directed cases
    run_op("basic", 16'd100, 8'd7, 16'd3);
    tick(); tick();
    chk("basic_stays", {8'd0, product}, 32'd703);
    run_op("roundtrip", 16'd3846, 8'd13, 16'd2);
    chk("roundtrip_50000", {8'd0, product}, 32'd50000);
    run_op("max", 16'd65535, 8'd255, 16'd65535);
    chk("max_ffff00", {8'd0, product}, 32'h00FF_FF00);
    run_op("b_zero", 16'd1234, 8'd0, 16'd56);
    chk("b_zero_56", {8'd0, product}, 32'd56);

    // Handshake: start during CALC ignored, then start held in DONE
    start = 1'b1; Q = 16'd5; B = 8'd5; R = 16'd0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        start = 1'b1; Q = 16'd9; B = 8'd9; R = 16'd9;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("hs_done", {31'd0, done}, 32'd1);
    chk("hs_ignore_product", {8'd0, product}, 32'd25);
    start = 1'b1; Q = 16'd2; B = 8'd3; R = 16'd1;
    ed = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        start = 1'b0;
        chk("hs_b2b_busy", {30'd0, busy, done}, 32'd2);
      end
      ed = i;
      if (done === 1'b1) break;
    end
    chk("hs_b2b_9cycles", ed, 32'd9);
    chk("hs_b2b_product", {8'd0, product}, {8'd0, model(16'd2, 8'd3, 16'd1)});
    last_prod = model(16'd2, 8'd3, 16'd1);
    tick();

    // Reset mid-operation
    start = 1'b1; Q = 16'd300; B = 8'd200; R = 16'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_product", {8'd0, product}, 32'd0);
    no_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0) no_done = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0) no_done = 1'b0;
      tick();
    end
    chk("midrst_no_done", {31'd0, no_done}, 32'd1);
    last_prod = '0;
    run_op("after_rst", 16'd300, 8'd200, 16'd7);

    // Randomized operands, including idle gaps between operations
    for (int k = 0; k < 8; k++) begin
      run_op("rand", 16'($urandom), 8'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
